serial_work_rx: RTL and testbench



---
 rtl/serial_work_rx.sv | 155 +++++++++++++++
 tb/tb_serial_work_rx.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/serial_work_rx.sv
// serial_work_rx: 8N1 UART receiver that assembles 64-byte work frames into a
// 256-bit midstate and a 256-bit data2 word, both updated atomically per frame.
module serial_work_rx #(
    parameter int unsigned comm_clk_frequency = 50_000_000,
    parameter int unsigned baud_rate          = 115_200,
    parameter int unsigned idle_timeout       = comm_clk_frequency / 10
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         RxD,
    output logic [255:0] midstate,
    output logic [255:0] data2,
    output logic         rx_done,
    output logic         byte_valid
);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    localparam int unsigned DIV = comm_clk_frequency / baud_rate;
    localparam int CW = $clog2(DIV);
    localparam int TW = $clog2(idle_timeout + 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(DIV / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(DIV - 1);
    localparam logic [TW-1:0] IDLE_LAST = TW'(idle_timeout - 1);

    logic          rx_meta;
    logic          rx_sync;
    logic          rx_prev;
    state_t        state;
    logic [CW-1:0] tick;
    logic [2:0]    bit_idx;
    logic [7:0]    rx_byte;
    logic          accept;
    logic [511:0]  shift;
    logic [5:0]    count;
    logic          load_pending;
    logic [TW-1:0] idle_cnt;

    // Synchronizer flops reset high so a reset never looks like a start edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= RxD;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    assign accept = (state == STOP) && (tick == BIT_LAST) && rx_sync;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            tick       <= '0;
            bit_idx    <= '0;
            rx_byte    <= '0;
            byte_valid <= 1'b0;
        end else begin
            byte_valid <= accept;
            case (state)
                IDLE: begin
                    tick <= '0;
                    // A falling edge needs a high sample first, which also re-arms after a framing error.
                    if (rx_prev && !rx_sync) begin
                        state <= START;
                    end
                end
                START: begin
                    if (tick == HALF_LAST) begin
                        tick    <= '0;
                        bit_idx <= '0;
                        state   <= rx_sync ? IDLE : DATA;
                    end else begin
                        tick <= tick + CW'(1);
                    end
                end
                DATA: begin
                    if (tick == BIT_LAST) begin
                        tick    <= '0;
                        rx_byte <= {rx_sync, rx_byte[7:1]};
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        tick <= tick + CW'(1);
                    end
                end
                STOP: begin
                    if (tick == BIT_LAST) begin
                        tick  <= '0;
                        state <= IDLE;
                    end else begin
                        tick <= tick + CW'(1);
                    end
                end
                default: begin
                    tick  <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Frame assembly and idle timeout; an accepted byte takes priority over the timeout.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shift        <= '0;
            count        <= '0;
            load_pending <= 1'b0;
            idle_cnt     <= '0;
        end else begin
            if (accept) begin
                shift        <= {shift[503:0], rx_byte};
                count        <= count + 6'd1;
                load_pending <= (count == 6'd63);
                idle_cnt     <= '0;
            end else begin
                load_pending <= 1'b0;
                if (state != IDLE || count == 6'd0) begin
                    idle_cnt <= '0;
                end else if (idle_cnt == IDLE_LAST) begin
                    idle_cnt <= '0;
                    count    <= '0;
                end else begin
                    idle_cnt <= idle_cnt + TW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            midstate <= '0;
            data2    <= '0;
            rx_done  <= 1'b0;
        end else begin
            rx_done <= load_pending;
            if (load_pending) begin
                midstate <= shift[511:256];
                data2    <= shift[255:0];
            end
        end
    end

endmodule

// File: tb/tb_serial_work_rx.sv
// Self-checking bench for serial_work_rx: randomized 8N1 traffic compared
// against a byte-queue model of frame assembly, timeout and reset behaviour.
module tb_serial_work_rx;

    localparam int unsigned CLK_HZ  = 1_152_000;
    localparam int unsigned BAUD    = 115_200;
    localparam int unsigned DIV     = CLK_HZ / BAUD;
    localparam int unsigned TIMEOUT = 400;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         rxd;
    logic [255:0] midstate;
    logic [255:0] data2;
    logic         rx_done;
    logic         byte_valid;

    serial_work_rx #(
        .comm_clk_frequency(CLK_HZ),
        .baud_rate(BAUD),
        .idle_timeout(TIMEOUT)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .RxD(rxd),
        .midstate(midstate),
        .data2(data2),
        .rx_done(rx_done),
        .byte_valid(byte_valid)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    int bv_cnt = 0;
    int done_cnt = 0;

    logic [7:0]   frame_q[$];
    logic [255:0] exp_mid = '0;
    logic [255:0] exp_d2 = '0;
    int           exp_frames = 0;
    int           exp_bytes = 0;

    always @(negedge clk) begin
        if (byte_valid === 1'b1) bv_cnt++;
        if (rx_done === 1'b1) done_cnt++;
    end

    task automatic checkOutput(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Reference model: every good byte joins the frame; the 64th publishes it.
    task automatic model_accept(input logic [7:0] b);
        exp_bytes++;
        frame_q.push_back(b);
        if (frame_q.size() == 64) begin
            for (int i = 0; i < 32; i++) begin
                exp_mid[255 - 8*i -: 8] = frame_q[i];
                exp_d2[255 - 8*i -: 8]  = frame_q[32 + i];
            end
            exp_frames++;
            frame_q.delete();
        end
    endtask

    task automatic drive_bit(input logic v);
        rxd = v;
        repeat (DIV) @(negedge clk);
    endtask

    task automatic idle_for(input int cycles);
        rxd = 1'b1;
        repeat (cycles) @(negedge clk);
        if (cycles > int'(TIMEOUT) + 40) frame_q.delete();
    endtask

    task automatic applyStimulus(input logic [7:0] b, input logic good_stop, input int gap_bits);
        int gap;
        gap = (!good_stop && gap_bits < 1) ? 1 : gap_bits;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(good_stop);
        if (good_stop) model_accept(b);
        idle_for(gap * int'(DIV));
    endtask

    task automatic check_frame(input string tag, input int bv0, input int d0, input int eb0, input int ef0);
        checkOutput({tag, "_bytes"}, 256'(bv_cnt - bv0), 256'(exp_bytes - eb0));
        checkOutput({tag, "_done"}, 256'(done_cnt - d0), 256'(exp_frames - ef0));
        checkOutput({tag, "_mid"}, midstate, exp_mid);
        checkOutput({tag, "_data2"}, data2, exp_d2);
    endtask

    initial begin
        int bv0, d0, eb0, ef0, target, sent;
        logic [255:0] held_mid, held_d2;

        // Reset with a noisy line: nothing may come out.
        reset_n = 1'b0;
        rxd = 1'b1;
        repeat (40) begin
            @(negedge clk);
            rxd = 1'($urandom);
        end
        checkOutput("reset_mid", midstate, '0);
        checkOutput("reset_data2", data2, '0);
        checkOutput("reset_pulses", 256'(bv_cnt + done_cnt), '0);
        rxd = 1'b1;
        repeat (5) @(negedge clk);
        reset_n = 1'b1;
        idle_for(30);

        // Incrementing frame 0x00..0x3F.
        bv0 = bv_cnt; d0 = done_cnt; eb0 = exp_bytes; ef0 = exp_frames;
        for (int i = 0; i < 64; i++) applyStimulus(8'(i), 1'b1, $urandom_range(0, 2));
        idle_for(20);
        check_frame("inc", bv0, d0, eb0, ef0);
        checkOutput("inc_first_byte", 256'(midstate[255:248]), 256'(8'h00));
        checkOutput("inc_last_byte", 256'(data2[7:0]), 256'(8'h3F));

        // Partial frame dropped by the idle timeout, then an all-A5 frame.
        bv0 = bv_cnt; d0 = done_cnt; eb0 = exp_bytes; ef0 = exp_frames;
        held_mid = midstate; held_d2 = data2;
        for (int i = 0; i < 10; i++) applyStimulus(8'($urandom), 1'b1, $urandom_range(0, 2));
        idle_for(500);
        checkOutput("partial_mid_held", midstate, held_mid);
        checkOutput("partial_d2_held", data2, held_d2);
        for (int i = 0; i < 64; i++) applyStimulus(8'hA5, 1'b1, $urandom_range(0, 2));
        idle_for(20);
        check_frame("a5", bv0, d0, eb0, ef0);
        checkOutput("a5_const", midstate, {32{8'hA5}});

        // Framing error on byte 5; 0x77 then completes the frame.
        bv0 = bv_cnt; d0 = done_cnt; eb0 = exp_bytes; ef0 = exp_frames;
        for (int i = 0; i < 64; i++) applyStimulus(8'($urandom), (i != 5), $urandom_range(0, 2));
        idle_for(20);
        checkOutput("ferr_bytes_63", 256'(bv_cnt - bv0), 256'(63));
        checkOutput("ferr_no_done", 256'(done_cnt - d0), '0);
        applyStimulus(8'h77, 1'b1, 1);
        idle_for(20);
        check_frame("ferr", bv0, d0, eb0, ef0);
        checkOutput("ferr_last_77", 256'(data2[7:0]), 256'(8'h77));

        // Short glitch, then a back-to-back frame with no inter-byte gap.
        bv0 = bv_cnt; d0 = done_cnt; eb0 = exp_bytes; ef0 = exp_frames;
        rxd = 1'b0;
        repeat (3) @(negedge clk);
        idle_for(40);
        checkOutput("glitch_no_byte", 256'(bv_cnt - bv0), '0);
        for (int i = 0; i < 64; i++) applyStimulus(8'($urandom), 1'b1, 0);
        idle_for(20);
        check_frame("b2b", bv0, d0, eb0, ef0);

        // Asynchronous reset in the middle of byte 40.
        for (int i = 0; i < 39; i++) applyStimulus(8'($urandom), 1'b1, $urandom_range(0, 1));
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'($urandom));
        #3;
        reset_n = 1'b0;
        #1;
        frame_q.delete();
        exp_mid = '0;
        exp_d2 = '0;
        checkOutput("rst_mid", midstate, exp_mid);
        checkOutput("rst_data2", data2, exp_d2);
        rxd = 1'b1;
        repeat (20) @(negedge clk);
        reset_n = 1'b1;
        idle_for(30);
        bv0 = bv_cnt; d0 = done_cnt; eb0 = exp_bytes; ef0 = exp_frames;
        for (int i = 0; i < 63; i++) applyStimulus(8'hFF, 1'b1, $urandom_range(0, 2));
        idle_for(20);
        checkOutput("rst_no_early_done", 256'(done_cnt - d0), '0);
        applyStimulus(8'hFF, 1'b1, 1);
        idle_for(20);
        check_frame("ff", bv0, d0, eb0, ef0);
        checkOutput("ff_const", midstate, {256{1'b1}});

        // Random traffic with occasional framing errors across two frames.
        bv0 = bv_cnt; d0 = done_cnt; eb0 = exp_bytes; ef0 = exp_frames;
        target = exp_frames + 2;
        sent = 0;
        while (exp_frames < target && sent < 400) begin
            applyStimulus(8'($urandom), ($urandom_range(0, 15) != 0), $urandom_range(0, 2));
            sent++;
        end
        idle_for(20);
        check_frame("rand", bv0, d0, eb0, ef0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
